// File: rtl/haz_detect_gen.sv
// Hazard detector for the ID/EX/MEM instruction window. It registers the data, store and control
// hazard flags and stalls or squashes the window on the resolver's replies. Macro HAZ_STATS_EN adds stat counters.
module haz_detect_gen #(
    parameter int REG_AW    = 5,
    parameter int STALL_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_load,
    input  logic              in_store,
    input  logic              in_branch,
    input  logic              in_pred_taken,
    input  logic              ex_taken,
    input  logic              res_resolved,
    input  logic              res_pc_freeze,
    input  logic              res_do_flush,
    output logic              in_ready,
    output logic              haz_data,
    output logic              haz_str,
    output logic              haz_ctrl,
    output logic              haz_fwrd,
    output logic              haz_crct,
    output logic              stall_to,
    input  logic              stat_sel,
    output logic [7:0]        stat_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              load;
        logic              store;
        logic              branch;
        logic              pred;
    } slot_t;

    localparam slot_t      BUBBLE      = '0;
    localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);

    slot_t             id_q;
    slot_t             ex_q;
    slot_t             mem_q;
    slot_t             in_slot;
    logic [REG_AW-1:0] id_rs1_q;
    logic [REG_AW-1:0] id_rs2_q;

    logic rs1_ex, rs1_mem, rs2_ex, rs2_mem;
    logic data_hit, load_use, str_hit, ctrl_hit, crct_hit;

    logic [7:0] stall_cnt;
    logic [7:0] stall_cnt_next;

    assign in_ready = ena & ~res_pc_freeze & ~res_do_flush;

    always_comb begin
        in_slot = BUBBLE;
        if (in_valid) begin
            in_slot.valid  = 1'b1;
            in_slot.rd     = in_rd;
            in_slot.load   = in_load;
            in_slot.store  = in_store;
            in_slot.branch = in_branch;
            in_slot.pred   = in_pred_taken;
        end
    end

    // Flush beats freeze; a freeze keeps ID and drains EX into MEM behind a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q     <= BUBBLE;
            ex_q     <= BUBBLE;
            mem_q    <= BUBBLE;
            id_rs1_q <= '0;
            id_rs2_q <= '0;
        end else if (ena) begin
            if (res_do_flush) begin
                id_q  <= BUBBLE;
                ex_q  <= BUBBLE;
                mem_q <= ex_q;
            end else if (res_pc_freeze) begin
                ex_q  <= BUBBLE;
                mem_q <= ex_q;
            end else begin
                mem_q    <= ex_q;
                ex_q     <= id_q;
                id_q     <= in_slot;
                id_rs1_q <= in_valid ? in_rs1 : '0;
                id_rs2_q <= in_valid ? in_rs2 : '0;
            end
        end
    end

    assign rs1_ex  = id_q.valid && (id_rs1_q != '0) && ex_q.valid  && (ex_q.rd  == id_rs1_q);
    assign rs1_mem = id_q.valid && (id_rs1_q != '0) && mem_q.valid && (mem_q.rd == id_rs1_q);
    assign rs2_ex  = id_q.valid && (id_rs2_q != '0) && ex_q.valid  && (ex_q.rd  == id_rs2_q);
    assign rs2_mem = id_q.valid && (id_rs2_q != '0) && mem_q.valid && (mem_q.rd == id_rs2_q);

    // A load feeding ID from EX cannot be forwarded and overrides any MEM match.
    assign data_hit = rs1_ex | rs1_mem | rs2_ex | rs2_mem;
    assign load_use = (rs1_ex | rs2_ex) & ex_q.load;
    assign str_hit  = id_q.valid & id_q.store & ex_q.valid & (ex_q.store | ex_q.load);
    assign ctrl_hit = ex_q.valid & ex_q.branch;
    assign crct_hit = ctrl_hit & (ex_taken == ex_q.pred);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haz_data <= 1'b0;
            haz_fwrd <= 1'b0;
            haz_str  <= 1'b0;
            haz_ctrl <= 1'b0;
            haz_crct <= 1'b0;
        end else begin
            haz_data <= data_hit;
            haz_fwrd <= data_hit & ~load_use;
            haz_str  <= str_hit;
            haz_ctrl <= ctrl_hit;
            haz_crct <= crct_hit;
        end
    end

    assign stall_cnt_next = (stall_cnt >= STALL_LIMIT) ? STALL_LIMIT : stall_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 8'd0;
            stall_to  <= 1'b0;
        end else if (res_pc_freeze) begin
            stall_cnt <= stall_cnt_next;
            if (stall_cnt_next == STALL_LIMIT) begin
                stall_to <= 1'b1;
            end
        end else begin
            stall_cnt <= 8'd0;
            if (res_resolved) begin
                stall_to <= 1'b0;
            end
        end
    end

`ifdef HAZ_STATS_EN
    logic [7:0] freeze_cnt;
    logic [7:0] flush_cnt;
    logic       flush_d;

    // Flush events count rising edges of the request, not cycles it is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze_cnt <= 8'd0;
            flush_cnt  <= 8'd0;
            flush_d    <= 1'b0;
        end else begin
            flush_d <= res_do_flush;
            if (res_pc_freeze && (freeze_cnt != 8'hFF)) begin
                freeze_cnt <= freeze_cnt + 8'd1;
            end
            if (res_do_flush && !flush_d && (flush_cnt != 8'hFF)) begin
                flush_cnt <= flush_cnt + 8'd1;
            end
        end
    end

    assign stat_cnt = stat_sel ? flush_cnt : freeze_cnt;
`else
    logic unused_stat_sel;

    assign unused_stat_sel = stat_sel;
    assign stat_cnt        = 8'h00;
`endif

endmodule
